bt_pen_axil_regbank: RTL
========================

BT_PEN_AXIL_REGBANK -- requirements
Module: bt_pen_axil_regbank

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, AXI4-Lite data width (32 or 64).
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 6, AXI4-Lite byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of read/write registers (1..(2^C_ADDR_WIDTH)/(C_DATA_WIDTH/8)-2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, receive byte FIFO depth (power of two, >=2).
REQ-005 ACLK  in  1  single clock, all logic rising-edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel.
REQ-008 s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  write data channel.
REQ-009 s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-010 s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address channel.
REQ-011 s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  C_DATA_WIDTH/2/1/1  read data channel.
REQ-012 rx_tdata  in  8  byte from Bluetooth UART receiver; rx_tvalid  in  1  one-cycle byte strobe (no backpressure).
REQ-013 irq  out  1  level interrupt, registered.

Function
REQ-014 Word index = addr[C_ADDR_WIDTH-1:log2(C_DATA_WIDTH/8)]; low address bits and *prot SHALL be ignored.
REQ-015 Map: index 0..NUM_REGS-1 = RW regs; NUM_REGS = STATUS; NUM_REGS+1 = RXDATA; higher = unmapped.
REQ-016 Write accept: awready and wready SHALL pulse high together for exactly one cycle when awvalid and wvalid are both high and bvalid is low; no single-channel acceptance.
REQ-017 bvalid SHALL rise the cycle after acceptance and hold until bready; bresp OKAY for mapped, SLVERR (2'b10) for unmapped (no state change).
REQ-018 RW reg write SHALL update only bytes whose wstrb bit is set.
REQ-019 STATUS layout: [7:0] fill level, [8] empty, [9] full, [10] overflow sticky; write with wdata[10]=1 and wstrb[1]=1 SHALL clear overflow; other bits read-only.
REQ-020 RXDATA writes SHALL be ignored with OKAY.
REQ-021 Read accept: arready SHALL pulse one cycle when arvalid high and rvalid low; rvalid next cycle, held with stable rdata/rresp until rready.
REQ-022 Unmapped read SHALL return rdata 0, rresp SLVERR.
REQ-023 RXDATA read: [7:0] head byte, [8] valid (1 when FIFO non-empty at acceptance); non-empty read SHALL pop exactly one byte at acceptance cycle; empty read returns 0, no pop.
REQ-024 rx_tvalid with FIFO not full SHALL push rx_tdata; with FIFO full SHALL drop the byte and set overflow.
REQ-025 Push and pop in same cycle SHALL leave level unchanged; push while full concurrent with pop SHALL be accepted (no overflow).
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level range 0..FIFO_DEPTH.
REQ-027 Overflow set and clear in same cycle: set SHALL win.
REQ-028 irq SHALL equal registered (!empty | overflow), one-cycle latency.
REQ-029 Read and write channels SHALL operate concurrently; read of a register written same cycle returns pre-write value.

Reset
REQ-030 While ARESETN low: awready, wready, arready, bvalid, rvalid, irq = 0; bresp, rresp, rdata = 0; RW regs = 0; FIFO empty, level 0, overflow 0.
REQ-031 Reset mid-transaction SHALL abandon it; no response issued after release.

Structure
REQ-032 Package bt_pen_pkg SHALL hold resp encodings (OKAY, SLVERR), STATUS bit positions, RXDATA valid bit index.
REQ-033 Receive FIFO SHALL be sub-module bt_pen_rx_fifo (push, pop, dout, level, full, empty), parametrised by depth.

Verification
REQ-034 Write 0x1,0x2,0x3,0x4 to index 0..3, read back -> each OKAY, data match.
REQ-035 Write 0xAABBCCDD then 0x11223344 wstrb 4'b0101 to index 0 -> read 0xAA22CC44.
REQ-036 Push bytes 0x41,0x42; read RXDATA twice, then third -> 0x141, 0x142, 0x000; STATUS level 2->0, irq 1->0.
REQ-037 Push FIFO_DEPTH+1 bytes -> STATUS full=1, overflow=1, level=16; write STATUS 0x400 -> overflow=0.
REQ-038 Read/write index NUM_REGS+2 -> SLVERR, rdata 0, RW regs unchanged.
REQ-039 Assert ARESETN low while bvalid high awaiting bready -> bvalid 0 immediately, regs 0 after release.

Source files
------------

// File: rtl/bt_pen_pkg.sv
// Shared encodings for the Bluetooth pen AXI4-Lite register bank: response codes,
// STATUS/RXDATA bit positions and the word-index region decoder.
package bt_pen_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_LEVEL_W     = 8;
  localparam int STAT_EMPTY_BIT   = 8;
  localparam int STAT_FULL_BIT    = 9;
  localparam int STAT_OVF_BIT     = 10;
  localparam int RXDATA_VALID_BIT = 8;

  typedef enum logic [1:0] {
    REGION_RW       = 2'd0,
    REGION_STATUS   = 2'd1,
    REGION_RXDATA   = 2'd2,
    REGION_UNMAPPED = 2'd3
  } region_e;

  // RW registers sit at the bottom, STATUS and RXDATA directly above them.
  function automatic region_e decode_region(input logic [31:0] idx, input logic [31:0] num_regs);
    region_e r;
    if (idx < num_regs) begin
      r = REGION_RW;
    end else if (idx == num_regs) begin
      r = REGION_STATUS;
    end else if (idx == num_regs + 32'd1) begin
      r = REGION_RXDATA;
    end else begin
      r = REGION_UNMAPPED;
    end
    return r;
  endfunction

endpackage

// File: rtl/bt_pen_axil_regbank_if.sv
// AXI4-Lite bus bundle for the Bluetooth pen register bank.
interface bt_pen_axil_regbank_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6
);
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/bt_pen_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, pointers wrap naturally, level spans 0..DEPTH.
module bt_pen_rx_fifo #(
  parameter int  DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_pop_s;
  logic             do_push_s;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == LVL_W'(0));
  assign level     = level_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_pop_s  = pop & ~empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push_s = push & (~full | do_pop_s);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      level_q  <= LVL_W'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/bt_pen_axil_regbank.sv
// AXI4-Lite register bank for a Bluetooth pen: RW registers, a FIFO STATUS word and
// an RXDATA pop port over received UART bytes, plus a level interrupt.
module bt_pen_axil_regbank
  import bt_pen_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int NUM_REGS     = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  bt_pen_axil_regbank_if.slave         s00_axi,
  input  logic [7:0]                   rx_tdata,
  input  logic                         rx_tvalid,
  output logic                         irq
);

  localparam int STRB_W   = C_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;

  logic [C_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [C_DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                    wr_ready_q, wr_ready_d;
  logic                    rd_ready_q, rd_ready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                    ovf_q, ovf_d;
  logic                    irq_q, irq_d;

  logic [IDX_W-1:0]        wr_idx_s, rd_idx_s;
  region_e                 wr_region_s, rd_region_s;
  logic                    wr_en_s, rd_en_s;
  logic                    ovf_clr_s, ovf_set_s;
  logic                    push_s, pop_s;
  logic [7:0]              fifo_dout_s;
  logic [LVL_W-1:0]        fifo_level_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic [C_DATA_WIDTH-1:0] status_s;
  logic                    unused_s;

  assign unused_s = ^{s00_axi.awprot, s00_axi.arprot,
                      s00_axi.awaddr[ADDR_LSB-1:0], s00_axi.araddr[ADDR_LSB-1:0]};

  assign wr_idx_s    = s00_axi.awaddr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx_s    = s00_axi.araddr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_region_s = decode_region(32'(wr_idx_s), 32'(NUM_REGS));
  assign rd_region_s = decode_region(32'(rd_idx_s), 32'(NUM_REGS));

  // Ready is only raised while the master holds valid, so ready&valid marks acceptance.
  assign wr_en_s = wr_ready_q & s00_axi.awvalid & s00_axi.wvalid;
  assign rd_en_s = rd_ready_q & s00_axi.arvalid;

  assign s00_axi.awready = wr_ready_q;
  assign s00_axi.wready  = wr_ready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = rd_ready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rresp   = rresp_q;
  assign s00_axi.rdata   = rdata_q;
  assign irq             = irq_q;

  bt_pen_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (push_s),
    .din   (rx_tdata),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  always_comb begin
    status_s                       = '0;
    status_s[STAT_LEVEL_W-1:0]     = STAT_LEVEL_W'(fifo_level_s);
    status_s[STAT_EMPTY_BIT]       = fifo_empty_s;
    status_s[STAT_FULL_BIT]        = fifo_full_s;
    status_s[STAT_OVF_BIT]         = ovf_q;
  end

  // Write channel: joint AW/W acceptance, byte-strobed RW update, overflow clear.
  always_comb begin
    wr_ready_d = s00_axi.awvalid & s00_axi.wvalid & ~bvalid_q & ~wr_ready_q;
    regs_d     = regs_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ovf_clr_s  = 1'b0;
    if (wr_en_s) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_region_s)
        REGION_RW: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
              if ((wr_idx_s == IDX_W'(i)) && s00_axi.wstrb[b]) begin
                regs_d[i][8*b +: 8] = s00_axi.wdata[8*b +: 8];
              end else begin
                regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8];
              end
            end
          end
        end
        REGION_STATUS: ovf_clr_s = s00_axi.wdata[STAT_OVF_BIT] & s00_axi.wstrb[STAT_OVF_BIT/8];
        REGION_RXDATA: bresp_d = RESP_OKAY;
        default:       bresp_d = RESP_SLVERR;
      endcase
    end else if (bvalid_q && s00_axi.bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // Read channel: data is captured from pre-write state; RXDATA pops at acceptance.
  always_comb begin
    rd_ready_d = s00_axi.arvalid & ~rvalid_q & ~rd_ready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    pop_s      = 1'b0;
    if (rd_en_s) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      case (rd_region_s)
        REGION_RW: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_s == IDX_W'(i)) begin
              rdata_d = regs_q[i];
            end else begin
              rdata_d = rdata_d;
            end
          end
        end
        REGION_STATUS: rdata_d = status_s;
        REGION_RXDATA: begin
          if (!fifo_empty_s) begin
            rdata_d[7:0]             = fifo_dout_s;
            rdata_d[RXDATA_VALID_BIT] = 1'b1;
            pop_s                    = 1'b1;
          end else begin
            rdata_d = '0;
            pop_s   = 1'b0;
          end
        end
        default: rresp_d = RESP_SLVERR;
      endcase
    end else if (rvalid_q && s00_axi.rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Overflow is sticky; a drop in the same cycle as a software clear keeps it set.
  always_comb begin
    push_s    = rx_tvalid & (~fifo_full_s | pop_s);
    ovf_set_s = rx_tvalid & fifo_full_s & ~pop_s;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    irq_d = ~fifo_empty_s | ovf_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

endmodule
